// File: rtl/accelerator_pkg.sv
// Shared types for the accelerator's data-memory arbitration logic.
// Owner and FSM state encodings used by vector_mem_arbiter and its owner FIFO.
package accelerator_pkg;

  typedef enum logic {
    ARB_OWNER_CORE,
    ARB_OWNER_VLSU
  } arb_owner_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_WAIT_GNT
  } arb_state_t;

  function automatic arb_owner_t arb_other_owner(input arb_owner_t owner);
    return (owner == ARB_OWNER_CORE) ? ARB_OWNER_VLSU : ARB_OWNER_CORE;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order record of which requester owns each granted memory transaction.
// Head is the owner of the oldest outstanding transaction.
module arb_owner_fifo
  import accelerator_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       push,
  input  arb_owner_t push_owner,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output arb_owner_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  arb_owner_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag keeps stale entries from ever being read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_owner;
  end

endmodule

// File: rtl/vector_mem_arbiter.sv
// Round-robin sharing of one OBI data-memory port between the core LSU and
// the vector LSU; responses are routed back in grant order via an owner FIFO.
module vector_mem_arbiter
  import accelerator_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  core_req_i,
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  input  logic                  core_we_i,
  input  logic [DATA_W/8-1:0]   core_be_i,
  input  logic [ADDR_W-1:0]     core_addr_i,
  input  logic [DATA_W-1:0]     core_wdata_i,
  output logic [DATA_W-1:0]     core_rdata_o,
  input  logic                  vlsu_req_i,
  output logic                  vlsu_gnt_o,
  output logic                  vlsu_rvalid_o,
  input  logic                  vlsu_we_i,
  input  logic [DATA_W/8-1:0]   vlsu_be_i,
  input  logic [ADDR_W-1:0]     vlsu_addr_i,
  input  logic [DATA_W-1:0]     vlsu_wdata_i,
  output logic [DATA_W-1:0]     vlsu_rdata_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic                  data_we_o,
  output logic [DATA_W/8-1:0]   data_be_o,
  output logic [ADDR_W-1:0]     data_addr_o,
  output logic [DATA_W-1:0]     data_wdata_o,
  input  logic [DATA_W-1:0]     data_rdata_i,
  output logic                  stray_rvalid_o
);

  arb_state_t state_q, state_d;
  arb_owner_t locked_q, locked_d;
  arb_owner_t rr_last_q;
  arb_owner_t sel_owner;
  arb_owner_t head_owner;
  logic       sel_valid;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  // Selection: the locked owner while waiting for a grant, otherwise round-robin.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_valid = 1'b0;
    sel_owner = ARB_OWNER_CORE;
    if (state_q == ARB_WAIT_GNT) begin
      sel_owner = locked_q;
      sel_valid = (locked_q == ARB_OWNER_CORE) ? core_req_i : vlsu_req_i;
    end else if (!fifo_full) begin
      if (core_req_i && vlsu_req_i) begin
        sel_owner = arb_other_owner(rr_last_q);
        sel_valid = 1'b1;
      end else if (core_req_i) begin
        sel_owner = ARB_OWNER_CORE;
        sel_valid = 1'b1;
      end else if (vlsu_req_i) begin
        sel_owner = ARB_OWNER_VLSU;
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    data_req_o   = sel_valid;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    if (sel_valid) begin
      if (sel_owner == ARB_OWNER_CORE) begin
        data_we_o    = core_we_i;
        data_be_o    = core_be_i;
        data_addr_o  = core_addr_i;
        data_wdata_o = core_wdata_i;
      end else begin
        data_we_o    = vlsu_we_i;
        data_be_o    = vlsu_be_i;
        data_addr_o  = vlsu_addr_i;
        data_wdata_o = vlsu_wdata_i;
      end
    end
  end

  assign push = data_req_o && data_gnt_i;
  assign pop  = data_rvalid_i && !fifo_empty;

  assign core_gnt_o = push && (sel_owner == ARB_OWNER_CORE);
  assign vlsu_gnt_o = push && (sel_owner == ARB_OWNER_VLSU);

  assign core_rvalid_o = pop && (head_owner == ARB_OWNER_CORE);
  assign vlsu_rvalid_o = pop && (head_owner == ARB_OWNER_VLSU);
  assign core_rdata_o  = data_rdata_i;
  assign vlsu_rdata_o  = data_rdata_i;

  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    case (state_q)
      ARB_IDLE: begin
        if (data_req_o && !data_gnt_i) begin
          state_d  = ARB_WAIT_GNT;
          locked_d = sel_owner;
        end
      end
      ARB_WAIT_GNT: begin
        // A withdrawn request is a protocol violation; recover without pushing.
        if (data_gnt_i || !data_req_o) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q        <= ARB_IDLE;
      locked_q       <= ARB_OWNER_CORE;
      rr_last_q      <= ARB_OWNER_VLSU;
      stray_rvalid_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      if (push) rr_last_q <= sel_owner;
      if (data_rvalid_i && fifo_empty) stray_rvalid_o <= 1'b1;
    end
  end

  arb_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk),
    .n_reset    (n_reset),
    .push       (push),
    .push_owner (sel_owner),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head_owner)
  );

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Directed bench for vector_mem_arbiter: inputs change 1ns after posedge,
// outputs are sampled 2ns after posedge.
module tb_vector_mem_arbiter;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        core_req_i, core_we_i, vlsu_req_i, vlsu_we_i;
  logic [3:0]  core_be_i, vlsu_be_i;
  logic [31:0] core_addr_i, core_wdata_i, vlsu_addr_i, vlsu_wdata_i;
  logic        core_gnt_o, core_rvalid_o, vlsu_gnt_o, vlsu_rvalid_o;
  logic [31:0] core_rdata_o, vlsu_rdata_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic        stray_rvalid_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  vector_mem_arbiter #(.MAX_OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .n_reset(n_reset),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_we_i(core_we_i), .core_be_i(core_be_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o),
    .vlsu_req_i(vlsu_req_i), .vlsu_gnt_o(vlsu_gnt_o), .vlsu_rvalid_o(vlsu_rvalid_o),
    .vlsu_we_i(vlsu_we_i), .vlsu_be_i(vlsu_be_i), .vlsu_addr_i(vlsu_addr_i),
    .vlsu_wdata_i(vlsu_wdata_i), .vlsu_rdata_o(vlsu_rdata_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .stray_rvalid_o(stray_rvalid_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    core_req_i = 0; core_we_i = 0; core_be_i = 4'hF; core_addr_i = 32'h0; core_wdata_i = 32'h0;
    vlsu_req_i = 0; vlsu_we_i = 0; vlsu_be_i = 4'hF; vlsu_addr_i = 32'h0; vlsu_wdata_i = 32'h0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    n_reset = 0;
    tick();
    tick();
    n_reset = 1;
    settle();
  endtask

  task automatic test_reset();
    idle_inputs();
    n_reset = 0;
    settle();
    total++; if (data_req_o !== 1'b0) $display("FAIL reset_req: got %0b want 0", data_req_o); else passed++;
    total++; if ({core_gnt_o, vlsu_gnt_o} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {core_gnt_o, vlsu_gnt_o}); else passed++;
    total++; if ({core_rvalid_o, vlsu_rvalid_o} !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", {core_rvalid_o, vlsu_rvalid_o}); else passed++;
    total++; if (stray_rvalid_o !== 1'b0) $display("FAIL reset_stray: got %0b want 0", stray_rvalid_o); else passed++;
    total++; if (data_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", data_addr_o); else passed++;
    tick();
    n_reset = 1;
    settle();
  endtask

  task automatic test_core_read();
    do_reset();
    core_req_i = 1; core_addr_i = 32'h0000_0100; core_be_i = 4'hF; data_gnt_i = 1;
    settle();
    total++; if (data_req_o !== 1'b1) $display("FAIL core_read_req: got %0b want 1", data_req_o); else passed++;
    total++; if (data_addr_o !== 32'h100) $display("FAIL core_read_addr: got %h want 00000100", data_addr_o); else passed++;
    total++; if (core_gnt_o !== 1'b1 || vlsu_gnt_o !== 1'b0) $display("FAIL core_read_gnt: got core=%0b vlsu=%0b want 1/0", core_gnt_o, vlsu_gnt_o); else passed++;
    tick();
    core_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 32'hDEADBEEF;
    settle();
    total++; if (core_rvalid_o !== 1'b1) $display("FAIL core_read_rvalid: got %0b want 1", core_rvalid_o); else passed++;
    total++; if (core_rdata_o !== 32'hDEADBEEF) $display("FAIL core_read_rdata: got %h want deadbeef", core_rdata_o); else passed++;
    total++; if (vlsu_rvalid_o !== 1'b0) $display("FAIL core_read_vlsu_rvalid: got %0b want 0", vlsu_rvalid_o); else passed++;
    tick();
    data_rvalid_i = 0;
  endtask

  task automatic test_round_robin();
    logic exp_gnt_core, exp_rsp_core;
    do_reset();
    core_addr_i = 32'h10; vlsu_addr_i = 32'h20;
    for (int i = 0; i < 5; i++) begin
      core_req_i = (i < 4); vlsu_req_i = (i < 4); data_gnt_i = (i < 4);
      data_rvalid_i = (i >= 1); data_rdata_i = 32'hA0 + i;
      settle();
      exp_gnt_core = (i % 2 == 0);
      exp_rsp_core = ((i - 1) % 2 == 0);
      if (i < 4) begin
        total++;
        if (core_gnt_o !== exp_gnt_core || vlsu_gnt_o !== !exp_gnt_core)
          $display("FAIL rr_gnt[%0d]: got core=%0b vlsu=%0b want core=%0b", i, core_gnt_o, vlsu_gnt_o, exp_gnt_core);
        else passed++;
        total++;
        if (data_addr_o !== (exp_gnt_core ? 32'h10 : 32'h20))
          $display("FAIL rr_addr[%0d]: got %h want %h", i, data_addr_o, exp_gnt_core ? 32'h10 : 32'h20);
        else passed++;
      end
      if (i >= 1) begin
        total++;
        if (core_rvalid_o !== exp_rsp_core || vlsu_rvalid_o !== !exp_rsp_core)
          $display("FAIL rr_rsp[%0d]: got core=%0b vlsu=%0b want core=%0b", i, core_rvalid_o, vlsu_rvalid_o, exp_rsp_core);
        else passed++;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_hold_locked();
    do_reset();
    vlsu_req_i = 1; vlsu_addr_i = 32'h200; core_addr_i = 32'h300;
    for (int i = 0; i < 3; i++) begin
      core_req_i = (i > 0); data_gnt_i = 0;
      settle();
      total++;
      if (data_addr_o !== 32'h200 || data_req_o !== 1'b1 || core_gnt_o !== 1'b0)
        $display("FAIL hold_addr[%0d]: got addr=%h req=%0b cgnt=%0b want 00000200/1/0", i, data_addr_o, data_req_o, core_gnt_o);
      else passed++;
      tick();
    end
    data_gnt_i = 1;
    settle();
    total++; if (vlsu_gnt_o !== 1'b1 || core_gnt_o !== 1'b0 || data_addr_o !== 32'h200)
      $display("FAIL hold_vlsu_gnt: got vgnt=%0b cgnt=%0b addr=%h want 1/0/00000200", vlsu_gnt_o, core_gnt_o, data_addr_o); else passed++;
    tick();
    vlsu_req_i = 0;
    settle();
    total++; if (core_gnt_o !== 1'b1 || data_addr_o !== 32'h300)
      $display("FAIL hold_core_gnt: got cgnt=%0b addr=%h want 1/00000300", core_gnt_o, data_addr_o); else passed++;
    tick();
    core_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1;
    settle();
    total++; if (vlsu_rvalid_o !== 1'b1 || core_rvalid_o !== 1'b0)
      $display("FAIL hold_rsp0: got v=%0b c=%0b want 1/0", vlsu_rvalid_o, core_rvalid_o); else passed++;
    tick();
    settle();
    total++; if (core_rvalid_o !== 1'b1 || vlsu_rvalid_o !== 1'b0)
      $display("FAIL hold_rsp1: got c=%0b v=%0b want 1/0", core_rvalid_o, vlsu_rvalid_o); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_full_block();
    do_reset();
    core_req_i = 1; core_addr_i = 32'h40; data_gnt_i = 1;
    tick();
    tick();
    settle();
    total++; if (data_req_o !== 1'b0 || core_gnt_o !== 1'b0)
      $display("FAIL full_block: got req=%0b gnt=%0b want 0/0", data_req_o, core_gnt_o); else passed++;
    tick();
    data_rvalid_i = 1;
    settle();
    total++; if (data_req_o !== 1'b0 || core_rvalid_o !== 1'b1)
      $display("FAIL full_pop_same_cycle: got req=%0b rvalid=%0b want 0/1", data_req_o, core_rvalid_o); else passed++;
    tick();
    data_rvalid_i = 0;
    settle();
    total++; if (data_req_o !== 1'b1 || core_gnt_o !== 1'b1)
      $display("FAIL full_unblock: got req=%0b gnt=%0b want 1/1", data_req_o, core_gnt_o); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_push_pop_same();
    do_reset();
    core_req_i = 1; core_addr_i = 32'h50; data_gnt_i = 1;
    tick();
    core_req_i = 0; vlsu_req_i = 1; vlsu_addr_i = 32'h60; data_rvalid_i = 1;
    settle();
    total++; if (vlsu_gnt_o !== 1'b1 || core_rvalid_o !== 1'b1)
      $display("FAIL pp_same_cycle: got vgnt=%0b crvalid=%0b want 1/1", vlsu_gnt_o, core_rvalid_o); else passed++;
    tick();
    vlsu_req_i = 0; core_req_i = 1; data_rvalid_i = 0;
    settle();
    total++; if (data_req_o !== 1'b1 || core_gnt_o !== 1'b1)
      $display("FAIL pp_count_one: got req=%0b cgnt=%0b want 1/1", data_req_o, core_gnt_o); else passed++;
    tick();
    core_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1;
    settle();
    total++; if (vlsu_rvalid_o !== 1'b1 || core_rvalid_o !== 1'b0)
      $display("FAIL pp_next_rsp: got v=%0b c=%0b want 1/0", vlsu_rvalid_o, core_rvalid_o); else passed++;
    tick();
    settle();
    total++; if (core_rvalid_o !== 1'b1 || vlsu_rvalid_o !== 1'b0)
      $display("FAIL pp_last_rsp: got c=%0b v=%0b want 1/0", core_rvalid_o, vlsu_rvalid_o); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_stray_and_reset();
    do_reset();
    data_rvalid_i = 1; data_rdata_i = 32'h1234;
    settle();
    total++; if (core_rvalid_o !== 1'b0 || vlsu_rvalid_o !== 1'b0)
      $display("FAIL stray_dropped: got c=%0b v=%0b want 0/0", core_rvalid_o, vlsu_rvalid_o); else passed++;
    tick();
    data_rvalid_i = 0;
    tick();
    tick();
    total++; if (stray_rvalid_o !== 1'b1) $display("FAIL stray_sticky: got %0b want 1", stray_rvalid_o); else passed++;
    vlsu_req_i = 1; vlsu_addr_i = 32'h70; core_addr_i = 32'h80;
    tick();
    settle();
    total++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h70)
      $display("FAIL wait_gnt_req: got req=%0b addr=%h want 1/00000070", data_req_o, data_addr_o); else passed++;
    idle_inputs();
    n_reset = 0;
    settle();
    total++; if (stray_rvalid_o !== 1'b0 || data_req_o !== 1'b0 || data_addr_o !== 32'h0)
      $display("FAIL midreset_outputs: got stray=%0b req=%0b addr=%h want 0/0/0", stray_rvalid_o, data_req_o, data_addr_o); else passed++;
    tick();
    n_reset = 1;
    tick();
    core_req_i = 1; vlsu_req_i = 1; core_addr_i = 32'h80; vlsu_addr_i = 32'h70;
    settle();
    total++; if (data_addr_o !== 32'h80 || data_req_o !== 1'b1)
      $display("FAIL midreset_idle: got addr=%h req=%0b want 00000080/1", data_addr_o, data_req_o); else passed++;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    n_reset = 1;
    test_reset();
    test_core_read();
    test_round_robin();
    test_hold_locked();
    test_full_block();
    test_push_pop_same();
    test_stray_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
